// File: rtl/stream_mux_rr_pkg.sv
// Shared mode encodings and pointer arithmetic for the stream multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Round-robin successor of channel g among n channels.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or after ptr wins, wrapping modulo N_CH.
module rr_arbiter #(
    parameter int N_CH = 4,
    localparam int SELW = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    localparam logic [SELW:0] NCH_W = (SELW+1)'(N_CH);

    logic [2*N_CH-1:0] req2;
    logic [N_CH-1:0]   rot;
    logic [SELW-1:0]   off;
    logic [SELW:0]     sum;

    // Doubling the request vector lets a plain right shift act as a rotate by ptr.
    assign req2 = {req, req};
    assign rot  = N_CH'(req2 >> ptr);

    // Lowest set bit of the rotated vector is the offset from ptr to the winner.
    always_comb begin
        gnt_valid = 1'b0;
        off       = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_valid = 1'b1;
                off       = SELW'(k);
            end
        end
    end

    // Map the offset back to an absolute channel index; ptr < N_CH so one subtract suffices.
    always_comb begin
        sum     = {1'b0, ptr} + {1'b0, off};
        gnt_idx = (sum >= NCH_W) ? SELW'(sum - NCH_W) : SELW'(sum);
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with fixed-select and round-robin modes.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32,
    localparam int SELW = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_src,
    input  logic                  out_ready
);

    localparam logic [SELW:0] NCH_W = (SELW+1)'(N_CH);

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [SELW-1:0]  src_p1;
    logic [SELW-1:0]  ptr_p1;

    logic             load;
    logic             fx_valid;
    logic             rr_valid;
    logic [SELW-1:0]  rr_idx;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic             xfer;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_p1),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Output register can take a new beat when empty or being drained this cycle.
    assign load = !vld_p1 || out_ready;

    // Out-of-range selects (non-power-of-2 N_CH) never grant.
    assign fx_valid = ({1'b0, sel} < NCH_W) && in_valid[sel];

    // Choose the grant source by mode; takes effect in the same cycle.
    always_comb begin
        if (mode == MODE_RR) begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end else begin
            gnt_valid = fx_valid;
            gnt_idx   = sel;
        end
    end

    // rst_n gates the handshake so nothing is offered while reset is held.
    assign xfer = rst_n && load && gnt_valid;

    // Only the granted channel sees ready.
    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[gnt_idx] = 1'b1;
    end

    // Output stage: capture on transfer, empty on drain without a grant, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            src_p1  <= '0;
        end else if (load) begin
            vld_p1 <= xfer;
            if (xfer) begin
                data_p1 <= in_data[gnt_idx*WIDTH +: WIDTH];
                src_p1  <= gnt_idx;
            end
        end
    end

    // Round-robin pointer advances past the winner of an RR-mode transfer only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_p1 <= '0;
        end else if (xfer && mode == MODE_RR) begin
            ptr_p1 <= SELW'(rr_next(32'(gnt_idx), N_CH));
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_src   = src_p1;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: directed scenarios plus randomized traffic.
module tb_stream_mux_rr;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] d;
        int           s;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mode = 1'b0;
    logic [1:0]     sel = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready = 1'b1;

    logic           mode3 = 1'b0;
    logic [1:0]     sel3 = '0;
    logic [2:0]     in_valid3 = '0;
    logic [3*W-1:0] in_data3 = '0;
    logic [2:0]     in_ready3;
    logic           out_valid3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_src3;
    logic           out_ready3 = 1'b1;

    int checks = 0;
    int failures = 0;

    beat_t q[$];
    bit    m_vld = 1'b0;
    int    m_ptr = 0;

    stream_mux_rr #(.N_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(3), .WIDTH(W)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_src(out_src3),
        .out_ready(out_ready3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setd(input int i, input logic [W-1:0] v);
        in_data[i*W +: W] = v;
    endtask

    // Reference model: evaluated mid-cycle on the inputs the next rising edge will sample.
    always @(negedge clk) begin
        int g;
        bit ld;
        logic [N-1:0] er;
        if (!rst_n) begin
            q.delete();
            m_vld = 1'b0;
            m_ptr = 0;
        end else begin
            ld = !m_vld || out_ready;
            g = -1;
            if (mode == 1'b0) begin
                if (int'(sel) < N && in_valid[sel]) g = int'(sel);
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            er = '0;
            if (ld && g >= 0) er[g] = 1'b1;
            chk("in_ready", in_ready, er);
            chk("out_valid", out_valid, m_vld);
            if (ld) begin
                m_vld = (g >= 0);
                if (g >= 0) begin
                    q.push_back('{d: in_data[g*W +: W], s: g});
                    if (mode == 1'b1) m_ptr = (g + 1) % N;
                end
            end
        end
    end

    // Monitor: every beat the consumer accepts must match the oldest expected beat.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                b = q.pop_front();
                chk("sb_data", out_data, b.d);
                chk("sb_src", out_src, b.s);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);

        // Fixed select of channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < N; i++) setd(i, W'(i + 1));
        #1;
        chk("fixed_in_ready", in_ready, 4'b0100);
        step();
        chk("fixed_out_data", out_data, 3);
        chk("fixed_out_src", out_src, 2);

        // Round-robin fairness, pointer still at 0
        mode = 1'b1;
        for (int i = 0; i < N; i++) setd(i, W'(32'h10 * (i + 1)));
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_src", out_src, k % N);
            chk("rr_data", out_data, 32'h10 * ((k % N) + 1));
        end

        // Backpressure with beat 2 from channel 1 held
        mode = 1'b0; sel = 2'd1; setd(1, 32'd2);
        step();
        chk("bp_load_data", out_data, 2);
        out_ready = 1'b0; setd(1, 32'd7);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            step();
            chk("bp_hold_data", out_data, 2);
            chk("bp_hold_src", out_src, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 4'b0010);
        step();
        chk("bp_next_data", out_data, 7);
        chk("bp_next_valid", out_valid, 1);

        // Sparse RR wrap: drive ptr to 3 via a channel-2 transfer
        mode = 1'b1; in_valid = 4'b0100;
        step();
        chk("wrap_prep_src", out_src, 2);
        in_valid = 4'b0010;
        #1;
        chk("wrap_grant1", in_ready, 4'b0010);
        step();
        chk("wrap_src1", out_src, 1);
        in_valid = 4'b0101;
        #1;
        chk("wrap_grant2", in_ready, 4'b0100);
        step();
        chk("wrap_src2", out_src, 2);
        in_valid = '0;
        step();

        // Out-of-range select on a 3-channel instance
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        #1;
        chk("oor_in_ready", in_ready3, 0);
        step(2);
        chk("oor_out_valid", out_valid3, 0);
        chk("oor_in_ready_late", in_ready3, 0);
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_ready", in_ready3, 3'b100);
        step();
        chk("n3_sel2_src", out_src3, 2);
        in_valid3 = '0;

        // Asynchronous reset with a beat held under stall
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; setd(0, 32'h5);
        step();
        out_ready = 1'b0;
        chk("pre_rst_data", out_data, 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_in_ready", in_ready, 0);
        step(2);
        chk("arst_held_ready", in_ready, 0);
        rst_n = 1'b1; out_ready = 1'b1; in_valid = '0;
        step();
        chk("no_replay", out_valid, 0);

        // Randomized traffic, with one reset pulse in the middle
        for (int it = 0; it < 400; it++) begin
            mode = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            sel = 2'($urandom_range(0, N - 1));
            in_valid = 4'($urandom);
            for (int i = 0; i < N; i++) setd(i, $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (it == 200) begin
                #2;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end

        in_valid = '0; out_ready = 1'b1;
        step(3);
        chk("drain_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
